rv_lsu: RTL and testbench

- Load/store unit: consumes the decoder's memory controls (mem_write, mem_op) plus the ALU-computed address and rs2 data, and executes the access on a word-wide data-memory bus.
- On the store side it generates byte enables and lane-replicated write data.
- On the load side it extracts the addressed lane and applies sign or zero extension.
- Sits between execute and writeback and drives the core's data-memory port.

---
 rtl/rv_lsu_if.sv | 41 ++++
 rtl/rv_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_rv_lsu.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_lsu_if.sv
// Request/response and data-memory bus bundle for the rv_lsu load/store unit.
// slave = LSU side, master = execute stage plus memory environment.
interface rv_lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_op;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    logic                  bus_req;
    logic                  bus_we;
    logic [DATA_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_WIDTH-1:0] bus_rdata;

    modport slave (
        input  req_valid, req_write, req_op, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport master (
        output req_valid, req_write, req_op, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/rv_lsu.sv
// rv_lsu: one-outstanding load/store unit with byte lanes, extension and error response.
// Optional macro RV_LSU_TIMEOUT_EN aborts a bus phase after TIMEOUT_CYCLES stalled cycles.
module rv_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic     clk,
    input logic     rst_n,
    rv_lsu_if.slave lsu
);
    typedef enum logic [1:0] {IDLE, ADDR, RDATA, RESP} state_t;

    state_t                r_state;
    logic                  r_write;
    logic [2:0]            r_op;
    logic [1:0]            r_addr_lo;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [DATA_WIDTH-1:0] r_bus_addr;
    logic [3:0]            r_bus_be;
    logic [DATA_WIDTH-1:0] r_bus_wdata;

    logic                  w_is_byte;
    logic                  w_is_half;
    logic                  w_is_word;
    logic                  w_op_legal;
    logic                  w_misaligned;
    logic                  w_req_err;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic                  w_ld_sext;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_wait_expired;

`ifdef RV_LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] r_wait_cnt;

    // Limit counts the current cycle, so a handshake in that same cycle still wins.
    assign w_wait_expired = ((r_wait_cnt + 8'd1) == TO_LIMIT);
`else
    assign w_wait_expired = 1'b0;
`endif

    assign lsu.req_ready  = (r_state == IDLE);
    assign lsu.resp_valid = r_resp_valid;
    assign lsu.resp_err   = r_resp_err;
    assign lsu.resp_rdata = r_resp_rdata;
    assign lsu.bus_req    = r_bus_req;
    assign lsu.bus_we     = r_bus_we;
    assign lsu.bus_addr   = r_bus_addr;
    assign lsu.bus_be     = r_bus_be;
    assign lsu.bus_wdata  = r_bus_wdata;

    // Request decode: size, legality (unsigned stores are illegal) and alignment.
    always_comb begin
        w_is_byte = (lsu.req_op[1:0] == 2'b01);
        w_is_half = (lsu.req_op[1:0] == 2'b10);
        w_is_word = (lsu.req_op == 3'b011);
        case (lsu.req_op)
            3'b001, 3'b010, 3'b011: w_op_legal = 1'b1;
            3'b101, 3'b110:         w_op_legal = !lsu.req_write;
            default:                w_op_legal = 1'b0;
        endcase
        w_misaligned = (w_is_half && lsu.req_addr[0]) ||
                       (w_is_word && (lsu.req_addr[1:0] != 2'b00));
        w_req_err    = !w_op_legal || w_misaligned;
        if (w_is_byte) begin
            w_be = 4'b0001 << lsu.req_addr[1:0];
        end else if (w_is_half) begin
            w_be = 4'b0011 << {lsu.req_addr[1], 1'b0};
        end else begin
            w_be = 4'b1111;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign w_wdata[8*gi +: 8] = w_is_byte ? lsu.req_wdata[7:0] :
                                        w_is_half ? lsu.req_wdata[8*(gi%2) +: 8] :
                                                    lsu.req_wdata[8*gi +: 8];
        end
    endgenerate

    // Load lane extraction uses the request fields latched at acceptance.
    always_comb begin
        case (r_addr_lo)
            2'd0:    w_ld_byte = lsu.bus_rdata[7:0];
            2'd1:    w_ld_byte = lsu.bus_rdata[15:8];
            2'd2:    w_ld_byte = lsu.bus_rdata[23:16];
            default: w_ld_byte = lsu.bus_rdata[31:24];
        endcase
        w_ld_half = r_addr_lo[1] ? lsu.bus_rdata[31:16] : lsu.bus_rdata[15:0];
        w_ld_sext = !r_op[2];
        if (r_op[1:0] == 2'b01) begin
            w_ld_data = {{(DATA_WIDTH-8){w_ld_sext && w_ld_byte[7]}}, w_ld_byte};
        end else if (r_op[1:0] == 2'b10) begin
            w_ld_data = {{(DATA_WIDTH-16){w_ld_sext && w_ld_half[15]}}, w_ld_half};
        end else begin
            w_ld_data = lsu.bus_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_op         <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
`ifdef RV_LSU_TIMEOUT_EN
            r_wait_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        r_write   <= lsu.req_write;
                        r_op      <= lsu.req_op;
                        r_addr_lo <= lsu.req_addr[1:0];
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= ADDR;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= lsu.req_write;
                            r_bus_addr  <= {lsu.req_addr[DATA_WIDTH-1:2], 2'b00};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
`ifdef RV_LSU_TIMEOUT_EN
                            r_wait_cnt  <= '0;
`endif
                        end
                    end
                end
                ADDR: begin
                    if (lsu.bus_gnt) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        if (r_write) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state <= RDATA;
`ifdef RV_LSU_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end
                    end else if (w_wait_expired) begin
                        r_bus_req    <= 1'b0;
                        r_bus_we     <= 1'b0;
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
`ifdef RV_LSU_TIMEOUT_EN
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end
                RDATA: begin
                    if (lsu.bus_rvalid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_ld_data;
                    end else if (w_wait_expired) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else begin
`ifdef RV_LSU_TIMEOUT_EN
                        r_wait_cnt <= r_wait_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: driver plans each access and queues expectations,
// a negedge monitor compares bus activity and responses against those queues.
module tb_rv_lsu;
    localparam int TO = 4;
`ifdef RV_LSU_TIMEOUT_EN
    localparam int TO_MODEL = TO;
`else
    localparam int TO_MODEL = 1 << 30;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_lsu_if #(.DATA_WIDTH(32)) lif ();

    rv_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lsu   (lif.slave)
    );

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          first;
        int          last;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    cyc      = 0;
    int    n_checks = 0;
    int    n_fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: size/sign/legality from the op table, lanes by plain arithmetic.
    function automatic void model_req(input logic w, input logic [2:0] op, input logic [31:0] addr,
                                      output bit ok, output int size, output bit sgn);
        case (op)
            3'b001, 3'b101: size = 1;
            3'b010, 3'b110: size = 2;
            default:        size = 4;
        endcase
        sgn = (op == 3'b001) || (op == 3'b010);
        ok  = (op == 3'b001) || (op == 3'b010) || (op == 3'b011) ||
              (((op == 3'b101) || (op == 3'b110)) && !w);
        if (ok && ((int'(addr[1:0]) % size) != 0)) ok = 1'b0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] addr, input int size);
        logic [3:0] be;
        int         off;
        off = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input int size);
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input int size, input bit sgn);
        logic [31:0] v;
        logic [31:0] mask;
        if (size == 4) return rdata;
        v    = rdata >> (8 * int'(addr[1:0]));
        mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v    = v & mask;
        if (sgn && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        resp_t e;
        logic  exp_req;
        if (rst_n) begin
            if (lif.resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", lif.resp_valid, 1'b0);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_err", lif.resp_err, e.err);
                    chk("resp_rdata", lif.resp_rdata, e.rdata);
                end
            end else if (resp_q.size() != 0 && cyc > resp_q[0].cyc) begin
                chk("resp_missing", lif.resp_valid, 1'b1);
                void'(resp_q.pop_front());
            end
            while (bus_q.size() != 0 && cyc > bus_q[0].last) void'(bus_q.pop_front());
            exp_req = (bus_q.size() != 0) && (cyc >= bus_q[0].first);
            chk("bus_req", lif.bus_req, exp_req);
            if (exp_req && lif.bus_req) begin
                chk("bus_we", lif.bus_we, bus_q[0].we);
                chk("bus_addr", lif.bus_addr, bus_q[0].addr);
                chk("bus_be", lif.bus_be, bus_q[0].be);
                chk("bus_wdata", lif.bus_wdata, bus_q[0].wdata);
            end
        end
    end

    task automatic noise();
        lif.bus_rvalid = 1'($urandom_range(0, 1));
        lif.bus_rdata  = $urandom;
    endtask

    // One access: gd = grant wait cycles, rd = rvalid wait cycles after grant.
    task automatic do_txn(input logic w, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gd, input int rd);
        bit    ok;
        bit    sgn;
        int    size;
        int    n;
        int    m;
        int    e_cyc;
        int    guard;
        resp_t r;
        bus_t  b;
        model_req(w, op, addr, ok, size, sgn);
        @(negedge clk);
        guard = 0;
        while (lif.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready", lif.req_ready, 1'b1);
        lif.req_valid = 1'b1;
        lif.req_write = w;
        lif.req_op    = op;
        lif.req_addr  = addr;
        lif.req_wdata = wdata;
        n = cyc;
        r.err   = 1'b0;
        r.rdata = '0;
        if (!ok) begin
            e_cyc = n + 1;
            r.err = 1'b1;
        end else begin
            b.first = n + 1;
            b.we    = w;
            b.addr  = {addr[31:2], 2'b00};
            b.be    = model_be(addr, size);
            b.wdata = model_wdata(wdata, size);
            if (gd >= TO_MODEL) begin
                b.last = n + TO_MODEL;
                e_cyc  = n + TO_MODEL + 1;
                r.err  = 1'b1;
            end else begin
                m      = n + 1 + gd;
                b.last = m;
                if (w) begin
                    e_cyc = m + 1;
                end else if (rd >= TO_MODEL) begin
                    e_cyc = m + TO_MODEL + 1;
                    r.err = 1'b1;
                end else begin
                    e_cyc   = m + 2 + rd;
                    r.rdata = model_load(rdata, addr, size, sgn);
                end
            end
            bus_q.push_back(b);
        end
        r.cyc = e_cyc;
        resp_q.push_back(r);
        @(posedge clk);
        #1;
        lif.req_valid = 1'b0;
        lif.req_addr  = $urandom;
        lif.req_wdata = $urandom;
        if (ok) begin
            for (int i = 0; i < gd && i < TO_MODEL; i++) begin
                @(negedge clk);
                lif.bus_gnt = 1'b0;
                noise();
            end
            if (gd < TO_MODEL) begin
                @(negedge clk);
                lif.bus_gnt = 1'b1;
                noise();
                if (!w) begin
                    for (int i = 0; i < rd && i < TO_MODEL; i++) begin
                        @(negedge clk);
                        lif.bus_gnt    = 1'b0;
                        lif.bus_rvalid = 1'b0;
                        lif.bus_rdata  = $urandom;
                    end
                    if (rd < TO_MODEL) begin
                        @(negedge clk);
                        lif.bus_gnt    = 1'b0;
                        lif.bus_rvalid = 1'b1;
                        lif.bus_rdata  = rdata;
                    end
                end
            end
            @(negedge clk);
            lif.bus_gnt    = 1'b0;
            lif.bus_rvalid = 1'b0;
        end
        while (cyc <= e_cyc) @(negedge clk);
        $display("txn we=%0d op=%03b addr=%08h wdata=%08h gd=%0d rd=%0d -> exp err=%0d rdata=%08h @%0d",
                 w, op, addr, wdata, gd, rd, r.err, r.rdata, e_cyc);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", lif.req_ready, 1'b1);
        chk("rst_resp_valid", lif.resp_valid, 1'b0);
        chk("rst_resp_err", lif.resp_err, 1'b0);
        chk("rst_resp_rdata", lif.resp_rdata, 32'h0);
        chk("rst_bus_req", lif.bus_req, 1'b0);
        chk("rst_bus_we", lif.bus_we, 1'b0);
        chk("rst_bus_addr", lif.bus_addr, 32'h0);
        chk("rst_bus_be", lif.bus_be, 4'h0);
        chk("rst_bus_wdata", lif.bus_wdata, 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [2:0]  op;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        int          n;
        bus_t        b;
        lif.req_valid  = 1'b0;
        lif.req_write  = 1'b0;
        lif.req_op     = 3'b000;
        lif.req_addr   = '0;
        lif.req_wdata  = '0;
        lif.bus_gnt    = 1'b0;
        lif.bus_rvalid = 1'b0;
        lif.bus_rdata  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        #2 rst_n = 1'b1;

        do_txn(1'b1, 3'b001, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
        do_txn(1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 3'b110, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0);
        do_txn(1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0000_F000, 3, 2);
        do_txn(1'b0, 3'b011, 32'h0000_0006, 32'h0, 32'h1234_5678, 0, 0);
        do_txn(1'b1, 3'b101, 32'h0000_0010, 32'h0000_0077, 32'h0, 0, 0);
        do_txn(1'b1, 3'b111, 32'h0000_0020, 32'h0000_0077, 32'h0, 0, 0);
        do_txn(1'b0, 3'b001, 32'h0000_0033, 32'h0, 32'h80FF_7F00, 0, 1);
        do_txn(1'b1, 3'b010, 32'h0000_0042, 32'hCAFE_BEEF, 32'h0, 1, 0);
        do_txn(1'b1, 3'b011, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 20, 0);
        do_txn(1'b0, 3'b011, 32'h0000_0104, 32'h0, 32'h1357_9BDF, 0, 20);
        do_txn(1'b0, 3'b011, 32'h0000_0108, 32'h0, 32'h2468_ACE0, TO - 1, TO - 1);

        for (int t = 0; t < 40; t++) begin
            wr   = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0:       op = 3'b001;
                    1:       op = 3'b010;
                    2:       op = 3'b011;
                    3:       op = 3'b101;
                    default: op = 3'b110;
                endcase
            end
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            do_txn(wr, op, a, wd, rdat, $urandom_range(0, 5), $urandom_range(0, 5));
        end

        // Reset while waiting for read data.
        @(negedge clk);
        lif.req_valid = 1'b1;
        lif.req_write = 1'b0;
        lif.req_op    = 3'b011;
        lif.req_addr  = 32'h0000_0040;
        lif.req_wdata = 32'h0;
        n = cyc;
        b.first = n + 1;
        b.last  = n + 1;
        b.we    = 1'b0;
        b.addr  = 32'h0000_0040;
        b.be    = model_be(32'h0000_0040, 4);
        b.wdata = model_wdata(32'h0, 4);
        bus_q.push_back(b);
        @(posedge clk);
        #1 lif.req_valid = 1'b0;
        @(negedge clk);
        lif.bus_gnt = 1'b1;
        @(negedge clk);
        lif.bus_gnt    = 1'b0;
        lif.bus_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        $display("txn reset asserted during read-data wait @%0d", cyc);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        chk("post_rst_ready", lif.req_ready, 1'b1);
        repeat (6) @(negedge clk);

        do_txn(1'b0, 3'b101, 32'h0000_0203, 32'h0, 32'hA5C3_0000, 0, 0);

        repeat (3) @(negedge clk);
        chk("final_resp_q_empty", resp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
